// File: rtl/ttl_arith_pkg.sv
// Shared constants and helpers for the TTL-style nibble adder chain.
// Imported by the slice and by the pipelined chain top.
package ttl_arith_pkg;

    localparam int NIB = 4;

    typedef logic [NIB-1:0] t_nib;

    // Flags registered alongside the final sum word.
    typedef struct packed {
        logic v;
        logic z;
    } t_flags;

    function automatic int stage_count(input int nibbles, input int nib_per_stage);
        return nibbles / nib_per_stage;
    endfunction

endpackage

// File: rtl/ttl_adder_slice.sv
// Combinational 4-bit carry-lookahead slice, modelled on a 74x283-style adder.
// Also exposes the carry into bit 3 so the caller can derive signed overflow.
module ttl_adder_slice
    import ttl_arith_pkg::*;
(
    input  logic [NIB-1:0] A,
    input  logic [NIB-1:0] B,
    input  logic           C_in,
    output logic [NIB-1:0] Sum,
    output logic           C_out,
    output logic           C_msb_in
);

    t_nib         g;
    t_nib         p;
    logic [NIB:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is a flat sum of products, so no carry ripples inside the slice.
    assign c[0] = C_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign Sum      = p ^ c[NIB-1:0];
    assign C_out    = c[NIB];
    assign C_msb_in = c[NIB-1];

endmodule

// File: rtl/ttl_adder_chain_pipe.sv
// Wide adder/subtractor built from 4-bit slices, with the inter-stage carry registered.
// Operands are skewed in and results de-skewed out so the whole word emerges aligned.
module ttl_adder_chain_pipe
    import ttl_arith_pkg::*;
#(
    parameter int NIBBLES       = 4,
    parameter int NIB_PER_STAGE = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Cen,
    input  logic                   In_valid,
    input  logic [NIB*NIBBLES-1:0] A,
    input  logic [NIB*NIBBLES-1:0] B,
    input  logic                   Sub,
    input  logic                   C_in,
    output logic                   Out_valid,
    output logic [NIB*NIBBLES-1:0] Sum,
    output logic                   C_out,
    output logic                   V_out,
    output logic                   Z_out
);

    localparam int W      = NIB * NIBBLES;
    localparam int STAGES = stage_count(NIBBLES, NIB_PER_STAGE);
    localparam int SW     = NIB * NIB_PER_STAGE;

    if (NIBBLES < 1 || NIBBLES > 8 || NIB_PER_STAGE < 1 ||
        (NIBBLES % NIB_PER_STAGE) != 0) begin : g_param_check
        $error("ttl_adder_chain_pipe: NIB_PER_STAGE must divide NIBBLES (1..8)");
    end

    logic [W-1:0]      b_eff;
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] valid_sr;
    logic [W-1:0]      sum_pre;
    logic [W-1:0]      sum_out;
    logic              v_pre;
    t_flags            flags_reg;

    // Inverting B once at the input keeps every skew register holding the effective operand.
    assign b_eff = Sub ? ~B : B;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            valid_sr <= '0;
        end else if (Cen) begin
            valid_sr[0] <= In_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;

        logic [SW-1:0]            a_stage;
        logic [SW-1:0]            b_stage;
        logic [SW-1:0]            s_comb;
        logic                     c_stage;
        logic                     carry_q;
        logic [NIB_PER_STAGE:0]   cc;
        logic [NIB_PER_STAGE-1:0] cmsb;
        logic                     unused_msb;
        logic [SW-1:0]            res_pipe [STAGES-k];

        if (k == 0) begin : g_head
            assign a_stage = A[LO +: SW];
            assign b_stage = b_eff[LO +: SW];
            assign c_stage = C_in;
        end else begin : g_skew
            logic [SW-1:0] a_dly [k];
            logic [SW-1:0] b_dly [k];

            // Upper operand nibbles wait k enabled cycles so they meet the carry from below.
            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_dly[i] <= '0;
                        b_dly[i] <= '0;
                    end
                end else if (Cen) begin
                    a_dly[0] <= A[LO +: SW];
                    b_dly[0] <= b_eff[LO +: SW];
                    for (int i = 1; i < k; i++) begin
                        a_dly[i] <= a_dly[i-1];
                        b_dly[i] <= b_dly[i-1];
                    end
                end
            end

            assign a_stage = a_dly[k-1];
            assign b_stage = b_dly[k-1];
            assign c_stage = carry_reg[k-1];
        end

        assign cc[0] = c_stage;

        for (genvar j = 0; j < NIB_PER_STAGE; j++) begin : g_slice
            ttl_adder_slice u_slice (
                .A        (a_stage[j*NIB +: NIB]),
                .B        (b_stage[j*NIB +: NIB]),
                .C_in     (cc[j]),
                .Sum      (s_comb[j*NIB +: NIB]),
                .C_out    (cc[j+1]),
                .C_msb_in (cmsb[j])
            );
        end

        assign unused_msb = ^cmsb;

        // Partial sum enters a de-skew line whose depth shrinks towards the top stage.
        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                carry_q <= 1'b0;
                for (int i = 0; i < STAGES - k; i++) begin
                    res_pipe[i] <= '0;
                end
            end else if (Cen) begin
                carry_q     <= cc[NIB_PER_STAGE];
                res_pipe[0] <= s_comb;
                for (int i = 1; i < STAGES - k; i++) begin
                    res_pipe[i] <= res_pipe[i-1];
                end
            end
        end

        assign carry_reg[k]      = carry_q;
        assign sum_out[LO +: SW] = res_pipe[STAGES-1-k];

        if (k == STAGES - 1) begin : g_tail
            assign sum_pre[LO +: SW] = s_comb;
            assign v_pre             = cmsb[NIB_PER_STAGE-1] ^ cc[NIB_PER_STAGE];
        end else begin : g_body
            assign sum_pre[LO +: SW] = res_pipe[STAGES-2-k];
        end
    end

    // sum_pre is the full word one edge before it lands on Sum, so the flags register in step.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            flags_reg <= '0;
        end else if (Cen) begin
            flags_reg.v <= v_pre;
            flags_reg.z <= ~|sum_pre;
        end
    end

    assign Sum       = sum_out;
    assign C_out     = carry_reg[STAGES-1];
    assign V_out     = flags_reg.v;
    assign Z_out     = flags_reg.z;
    assign Out_valid = valid_sr[STAGES-1];

endmodule

// File: tb/tb_ttl_adder_chain_pipe.sv
// Directed and scoreboarded stimulus for the pipelined nibble adder chain
// at its default geometry (4 nibbles, one nibble per stage, latency 4).
module tb_ttl_adder_chain_pipe;

    localparam int NIBBLES       = 4;
    localparam int NIB_PER_STAGE = 1;
    localparam int W             = 4 * NIBBLES;
    localparam int STAGES        = NIBBLES / NIB_PER_STAGE;

    logic         Clk;
    logic         Rst_n;
    logic         Cen;
    logic         In_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Sub;
    logic         C_in;
    logic         Out_valid;
    logic [W-1:0] Sum;
    logic         C_out;
    logic         V_out;
    logic         Z_out;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W+3:0] exp;
        int           idx;
    } sb_entry_t;

    vec_t      vecs [12];
    sb_entry_t sb [$];
    int        vec_count;
    int        miss_count;
    int        en_edges;
    int        popped;
    bit        last_en;
    bit        track_on;

    ttl_adder_chain_pipe #(
        .NIBBLES       (NIBBLES),
        .NIB_PER_STAGE (NIB_PER_STAGE)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Cen       (Cen),
        .In_valid  (In_valid),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .C_in      (C_in),
        .Out_valid (Out_valid),
        .Sum       (Sum),
        .C_out     (C_out),
        .V_out     (V_out),
        .Z_out     (Z_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Arithmetic reference: {valid, sum, carry, overflow, zero}.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cin};
        return {1'b1, full[W-1:0], full[W], low[W-1] ^ full[W], full[W-1:0] == '0};
    endfunction

    function automatic logic [W+3:0] observed();
        return {Out_valid, Sum, C_out, V_out, Z_out};
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin,
                                 input logic valid, input logic cen);
        A        = a;
        B        = b;
        Sub      = sub;
        C_in     = cin;
        In_valid = valid;
        Cen      = cen;
    endtask

    task automatic checkOutput(input string name, input logic [W+3:0] got,
                               input logic [W+3:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got {v,sum,c,v,z}=%b_%h_%b%b%b expected %b_%h_%b%b%b", name,
                     got[W+3], got[W+2:3], got[2], got[1], got[0],
                     exp[W+3], exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        vec_count++;
        if (got != exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drainScoreboard(input string name);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (sb.size() == 0) break;
        end
        @(negedge Clk);
        checkInt(name, sb.size(), 0);
    endtask

    // Input-side scoreboard: records each accepted op with the enabled-edge index that took it.
    always @(posedge Clk) begin
        if (!Rst_n) begin
            sb.delete();
            last_en = 1'b0;
        end else begin
            last_en = Cen;
            if (Cen) begin
                en_edges++;
                if (In_valid && track_on) begin
                    sb.push_back('{exp: model(A, B, Sub, C_in), idx: en_edges});
                end
            end
        end
    end

    // Output-side check: a fresh result appears only after an enabled edge.
    always @(negedge Clk) begin
        sb_entry_t e;
        if (track_on && last_en && Out_valid) begin
            if (sb.size() == 0) begin
                checkInt("stream_unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                popped++;
                checkOutput("stream_result", observed(), e.exp);
                checkInt("stream_latency", en_edges - e.idx, STAGES - 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcount;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        vec_count  = 0;
        miss_count = 0;
        en_edges   = 0;
        popped     = 0;
        track_on   = 1'b0;
        last_en    = 1'b0;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'hABCD, 16'h0000, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        Rst_n = 1'b0;
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge Clk);
        checkOutput("reset_state", observed(), '0);
        Rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b1, 1'b1);
            @(negedge Clk);
            applyStimulus(16'h5A5A, 16'hC3C3, 1'b0, 1'b1, 1'b0, 1'b1);
            repeat (STAGES - 2) @(negedge Clk);
            checkInt($sformatf("vec%0d_early_valid", i), int'(Out_valid), 0);
            @(negedge Clk);
            checkOutput($sformatf("vec%0d", i), observed(),
                        {1'b1, vecs[i].sum, vecs[i].c, vecs[i].v, vecs[i].z});
        end
        repeat (STAGES) @(negedge Clk);

        $display("[TB] back-to-back stream");
        track_on = 1'b1;
        vcount   = 0;
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs, rs | 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            @(negedge Clk);
            vcount += int'(Out_valid);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < STAGES; i++) begin
            @(negedge Clk);
            vcount += int'(Out_valid);
        end
        checkInt("b2b_valid_cycles", vcount, 100);
        drainScoreboard("b2b_drain");

        $display("[TB] random clock-enable stream");
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            @(negedge Clk);
        end
        drainScoreboard("cen_drain");

        $display("[TB] reset with operations in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h1111 * W'(i + 1), 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge Clk);
        end
        Rst_n = 1'b0;
        applyStimulus(16'h7777, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        checkOutput("reset_flush", observed(), '0);
        Rst_n = 1'b1;
        applyStimulus(16'h2468, 16'h1357, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        popped = 0;
        drainScoreboard("post_reset_drain");
        checkInt("post_reset_results", popped, 1);
        track_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
